// File: rtl/uart_tx_feeder_if.sv
// Producer/transmitter-side signal bundle for uart_tx_feeder.
// The slave modport is the feeder itself; master is whoever drives it.
interface uart_tx_feeder_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          tx_busy;
  logic          tx_en;
  logic [7:0]    tx_byte;
  logic          ovf_err;
  logic          tmo_err;
  logic          err_clr;

  modport master (
    output wr_en, wr_data, tx_busy, err_clr,
    input  full, empty, level, tx_en, tx_byte, ovf_err, tmo_err
  );

  modport slave (
    input  wr_en, wr_data, tx_busy, err_clr,
    output full, empty, level, tx_en, tx_byte, ovf_err, tmo_err
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus sequencer feeding a UART transmitter: one tx_en strobe per
// byte, tx_byte held for the whole frame, tx_busy handshake with timeout.
module uart_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int GAP_CYCLES = 0,
  parameter int BUSY_TMO   = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  uart_tx_feeder_if.slave bus
);
  localparam int               TW       = $clog2(BUSY_TMO + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(BUSY_TMO - 1);
  localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [AW:0]      DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      ONE_L    = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level, level_nxt;
  logic            full, empty;
  logic            tx_en, ovf_err, tmo_err;
  logic [7:0]      tx_byte;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      gap_cnt;
  logic            push, pop, ovf_set, tmo_set;

  assign push    = bus.wr_en && !full;
  assign ovf_set = bus.wr_en && full;
  assign pop     = (state == IDLE) && !empty && !bus.tx_busy;
  assign tmo_set = (state == WAIT_BUSY) && !bus.tx_busy && (tmo_cnt == TMO_LAST);

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + ONE_L;
    else if (pop && !push) level_nxt = level - ONE_L;
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == DEPTH_L);
      empty <= (level_nxt == '0);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      tx_byte <= 8'h00;
      tmo_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      tx_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_byte <= mem[rd_ptr];
            state   <= LOAD;
          end
        end
        LOAD: begin
          tx_en   <= 1'b1;
          tmo_cnt <= '0;
          state   <= START;
        end
        // tmo_cnt counts cycles since tx_en, so the START cycle is count 1.
        START: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy)  state <= WAIT_DONE;
          else if (tmo_set) state <= IDLE;
          else              tmo_cnt <= tmo_cnt + TW'(1);
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              state   <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear beats a coincident set; the coincident event is lost.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || bus.err_clr) begin
      ovf_err <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      if (ovf_set) ovf_err <= 1'b1;
      if (tmo_set) tmo_err <= 1'b1;
    end
  end

  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.level   = level;
  assign bus.tx_en   = tx_en;
  assign bus.tx_byte = tx_byte;
  assign bus.ovf_err = ovf_err;
  assign bus.tmo_err = tmo_err;
endmodule
